// File: rtl/sync_tx.sv
// Serial frame transmitter: emits a 0,0,1 marker, then the payload MSB-first with a 1
// stuffed after every payload 0, so "00" can only ever appear inside the marker.
module sync_tx #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid,
    output logic             ready,
    output logic             x,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SYNC0 = 3'd1,
        SYNC1 = 3'd2,
        SYNC2 = 3'd3,
        DATA  = 3'd4,
        STUFF = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             x_q, x_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Handshake: a word transfers on a rising edge where valid && ready; ready depends on state only.
    assign ready = (state_q == IDLE);
    assign x     = x_q;
    assign busy  = busy_q;
    assign done  = done_q;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (valid) begin
                    shreg_d = data_in;
                    cnt_d   = CW'(WIDTH);
                    state_d = SYNC0;
                end
            end
            SYNC0: state_d = SYNC1;
            SYNC1: state_d = SYNC2;
            SYNC2: state_d = DATA;
            DATA: begin
                // The bit on the line this cycle is the current MSB; shift it out on exit.
                shreg_d = shreg_q << 1;
                cnt_d   = cnt_q - CW'(1);
                if (!shreg_q[WIDTH-1]) begin
                    state_d = STUFF;
                end else if (cnt_d == '0) begin
                    state_d = IDLE;
                end else begin
                    state_d = DATA;
                end
            end
            STUFF: state_d = (cnt_q == '0) ? IDLE : DATA;
            default: state_d = IDLE;
        endcase

        // Outputs are registered, so they are decoded from the state being entered.
        unique case (state_d)
            SYNC0, SYNC1: x_d = 1'b0;
            DATA:         x_d = shreg_d[WIDTH-1];
            default:      x_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == IDLE) && ((state_q == DATA) || (state_q == STUFF));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            x_q     <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: doc/sync_tx.md
# sync_tx

Serial frame transmitter for the single-wire "001"-sync link. It accepts a WIDTH-bit word over a valid/ready handshake and emits one serial frame on `x`: the sync marker 0,0,1, then the payload MSB-first. After every payload 0 it inserts a stuffing 1, so the payload never contains two consecutive zeros and cannot alias the marker. It drives the downstream "001" sync detector, which sees exactly one marker per frame.

## Interface
Parameters:
- `WIDTH`, default 8: payload bits per frame. Legal range is WIDTH >= 1.

Ports:
- `clk`, input, 1: single clock. All state changes on its rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `data_in`, input, WIDTH: payload word. Sampled only on a handshake.
- `valid`, input, 1: upstream has a word to send.
- `ready`, output, 1: block can accept a word. Decoded from the state register only, with no combinational path from `valid`.
- `x`, output, 1: serial line. Registered. Idle level is 1.
- `busy`, output, 1: a frame is on the line. Registered.
- `done`, output, 1: one-cycle pulse after a frame completes. Registered.

## Operation
- The state machine has six states: IDLE, SYNC0, SYNC1, SYNC2, DATA, STUFF.
- IDLE:
  - Outputs: `x`=1, `ready`=1, `busy`=0.
  - If `valid`&`ready` is high at an edge, latch `data_in` into the shift register, load the bit counter with WIDTH, and go to SYNC0.
  - Otherwise stay in IDLE.
- SYNC0 and SYNC1 each drive `x`=0 for one cycle. SYNC2 drives `x`=1 for one cycle and then goes to DATA.
- DATA:
  - `x` = current MSB of the shift register. Then shift left by 1 and decrement the counter.
  - If the bit sent was 0, go to STUFF.
  - Else if the counter reaches 0, go to IDLE.
  - Else stay in DATA.
- STUFF drives `x`=1 for one cycle. Then go to IDLE if the counter is 0, otherwise back to DATA.
- `busy`=1 in every state except IDLE.
- `done`=1 only in the first IDLE cycle after DATA or STUFF exits. It is never high after reset.
- `valid` is ignored while `ready`=0. `data_in` may change freely outside the handshake cycle.
- Frame length in cycles = 3 + WIDTH + (number of 0 bits in the payload).
  - Minimum: 3 + WIDTH, for an all-ones payload.
  - Maximum: 3 + 2*WIDTH, for an all-zeros payload.
- The bit counter is $clog2(WIDTH+1) bits wide. It never wraps: it is loaded on the handshake and only decremented in DATA.
- Line invariants:
  - `00` appears only inside the marker.
  - Every 0 is immediately followed by either another marker 0 or a 1.
  - The line idles at 1 between frames.

## Timing
- Reset asserted (asynchronous, any time, including mid-frame):
  - Immediately `x`=1, `ready`=1, `busy`=0, `done`=0.
  - State returns to IDLE, shift register and counter are cleared, and the partial frame is abandoned.
- Release of reset is synchronous in effect: the first possible handshake is the first rising edge with `reset`=1.
- Handshake at edge k gives:
  - `x`=0 in cycles k+1 and k+2.
  - `x`=1 in cycle k+3.
  - First payload bit in cycle k+4.
  - `ready` and `busy` change at edge k.
- The last frame bit occupies cycle j. At edge j+1, `x`=1, `ready`=1, `busy`=0 and `done`=1.
- A handshake in that same cycle (`done`=1) is legal. The next frame then starts with `x`=0 at j+2.
- Minimum gap between frames is one idle cycle with `x`=1.
- Sustained throughput: one frame per (frame length + 1) cycles.

## Test plan
- **Reset values:** hold `reset`=0 for 3 cycles with `valid`=1 → `x`=1, `ready`=1, `busy`=0, `done`=0, and no frame starts.
- **Mixed payload (WIDTH=8, `data_in`=0xA5):**
  - `x` after the handshake = 0,0,1, 1, 0,1, 1, 0,1, 0,1, 1, 0,1, 1. That is 15 cycles.
  - Then `done` pulses once and `x`=1.
  - Looped into the 001 detector: exactly one detect pulse.
- **All-ones and all-zeros payloads:**
  - 0xFF gives an 11-cycle frame: 0,0,1 followed by eight 1s.
  - 0x00 gives a 19-cycle frame: 0,0,1 followed by (0,1)×8.
  - In both, `busy`=1 for exactly the frame length.
- **Back-to-back frames:** hold `valid`=1 with 0x3C then 0xC3.
  - The second handshake lands in the `done` cycle.
  - Exactly one idle 1 separates the frames, and the detector pulses exactly twice.
- **Ignored input while busy:** change `data_in` and toggle `valid` while `busy`=1 → the frame content is unchanged and no extra handshake occurs.
- **Reset mid-frame:** assert `reset` during the 5th payload bit of 0x00.
  - `x`=1 immediately (before the next edge), and `done` is not pulsed.
  - After release, a new 0x81 frame is emitted correctly: 0,0,1, 1, (0,1)×6, 1.
